// File: rtl/inst_rom_responder.sv
// Instruction ROM responder for the IF stage: accepts fetch requests, applies optional
// wait states, and returns the instruction word with an explicit valid flag and fetch error.
module inst_rom_responder #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned WAIT_STATES = 0,
  parameter string       INIT_FILE   = ""
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rom_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  hold,
  output logic                  rom_ready,
  output logic [DATA_WIDTH-1:0] inst,
  output logic [ADDR_WIDTH-1:0] inst_addr,
  output logic                  inst_valid,
  output logic                  addr_err
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W = 4;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t                  r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

  logic                    w_misaligned;
  logic                    w_out_of_range;
  logic                    w_err;
  logic                    w_accept;
  logic [DEPTH_LOG2-1:0]   w_rd_idx;
  logic [DATA_WIDTH-1:0]   w_rd_data;

  assign w_misaligned   = |addr[1:0];
  assign w_out_of_range = (addr >> (DEPTH_LOG2 + 2)) != '0;
  assign w_err          = w_misaligned | w_out_of_range;

  assign rom_ready = rst && (r_state == S_IDLE) && !(hold && inst_valid);
  assign w_accept  = rom_en && rom_ready;

  assign w_rd_idx  = (r_state == S_WAIT) ? r_addr[DEPTH_LOG2+1:2] : addr[DEPTH_LOG2+1:2];
  assign w_rd_data = r_mem[w_rd_idx];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_addr     <= '0;
      inst       <= '0;
      inst_addr  <= '0;
      inst_valid <= 1'b0;
      addr_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_err) begin
              inst       <= '0;
              inst_addr  <= addr;
              addr_err   <= 1'b1;
              inst_valid <= 1'b1;
            end else if (WAIT_STATES == 0) begin
              inst       <= w_rd_data;
              inst_addr  <= addr;
              addr_err   <= 1'b0;
              inst_valid <= 1'b1;
            end else begin
              r_state    <= S_WAIT;
              r_cnt      <= CNT_W'(WAIT_STATES);
              r_addr     <= addr;
              inst_valid <= 1'b0;
            end
          end else if (!hold) begin
            inst_valid <= 1'b0;
          end
        end
        S_WAIT: begin
          if (r_cnt == CNT_W'(1)) begin
            inst       <= w_rd_data;
            inst_addr  <= r_addr;
            addr_err   <= 1'b0;
            inst_valid <= 1'b1;
            r_state    <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_rom_responder.sv
// Bench: three responders (0, 2 and 3 wait states) driven in lockstep and compared every
// cycle against a transaction-level model of the fetch protocol.
module tb_inst_rom_responder;

    localparam int NDUT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        rom_en;
    logic        hold;
    logic [31:0] addr;

    logic        o_ready [NDUT];
    logic [31:0] o_inst  [NDUT];
    logic [31:0] o_iaddr [NDUT];
    logic        o_valid [NDUT];
    logic        o_err   [NDUT];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    inst_rom_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_LOG2(10), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst(rst), .rom_en(rom_en), .addr(addr), .hold(hold),
        .rom_ready(o_ready[0]), .inst(o_inst[0]), .inst_addr(o_iaddr[0]),
        .inst_valid(o_valid[0]), .addr_err(o_err[0]));

    inst_rom_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_LOG2(10), .WAIT_STATES(2)) u_ws2 (
        .clk(clk), .rst(rst), .rom_en(rom_en), .addr(addr), .hold(hold),
        .rom_ready(o_ready[1]), .inst(o_inst[1]), .inst_addr(o_iaddr[1]),
        .inst_valid(o_valid[1]), .addr_err(o_err[1]));

    inst_rom_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_LOG2(10), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .rst(rst), .rom_en(rom_en), .addr(addr), .hold(hold),
        .rom_ready(o_ready[2]), .inst(o_inst[2]), .inst_addr(o_iaddr[2]),
        .inst_valid(o_valid[2]), .addr_err(o_err[2]));

    // Reference model: each responder is either free or owes one response due at a
    // known edge number; visible outputs are the last response delivered.
    int          ws        [NDUT];
    bit          pend      [NDUT];
    int          due       [NDUT];
    logic [31:0] pend_addr [NDUT];
    logic [31:0] exp_inst  [NDUT];
    logic [31:0] exp_iaddr [NDUT];
    bit          exp_valid [NDUT];
    bit          exp_err   [NDUT];
    int          cyc = 0;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return (a >> 2) + 32'h100;
    endfunction

    function automatic bit bad_addr(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a >= 32'h1000);
    endfunction

    function automatic bit exp_ready(input int d);
        return rst && !pend[d] && !(hold && exp_valid[d]);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < NDUT; d++) begin
            pend[d]      = 1'b0;
            exp_inst[d]  = '0;
            exp_iaddr[d] = '0;
            exp_valid[d] = 1'b0;
            exp_err[d]   = 1'b0;
        end
    endtask

    task automatic deliver(input int d, input logic [31:0] a);
        exp_valid[d] = 1'b1;
        exp_iaddr[d] = a;
        exp_err[d]   = bad_addr(a);
        exp_inst[d]  = bad_addr(a) ? 32'h0 : rom_word(a);
    endtask

    task automatic model_edge();
        cyc++;
        for (int d = 0; d < NDUT; d++) begin
            if (pend[d]) begin
                if (cyc == due[d]) begin
                    deliver(d, pend_addr[d]);
                    pend[d] = 1'b0;
                end
            end else if (rom_en && exp_ready(d)) begin
                if (bad_addr(addr) || ws[d] == 0) begin
                    deliver(d, addr);
                end else begin
                    pend[d]      = 1'b1;
                    due[d]       = cyc + ws[d];
                    pend_addr[d] = addr;
                    exp_valid[d] = 1'b0;
                end
            end else if (!(hold && exp_valid[d])) begin
                exp_valid[d] = 1'b0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_ready();
        for (int d = 0; d < NDUT; d++)
            chk($sformatf("ready[ws%0d]", ws[d]), 32'(o_ready[d]), 32'(exp_ready(d)));
    endtask

    task automatic check_outputs();
        for (int d = 0; d < NDUT; d++) begin
            chk($sformatf("valid[ws%0d]", ws[d]), 32'(o_valid[d]), 32'(exp_valid[d]));
            chk($sformatf("inst[ws%0d]", ws[d]),  o_inst[d],         exp_inst[d]);
            chk($sformatf("iaddr[ws%0d]", ws[d]), o_iaddr[d],        exp_iaddr[d]);
            chk($sformatf("err[ws%0d]", ws[d]),   32'(o_err[d]),     32'(exp_err[d]));
        end
    endtask

    // Called just after a falling edge: drive, check ready, clock, check outputs.
    task automatic step(input bit en, input logic [31:0] a, input bit h);
        rom_en = en;
        addr   = a;
        hold   = h;
        #1;
        check_ready();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0);
    endtask

    // Asynchronous reset asserted between edges, released on a later falling edge.
    task automatic pulse_reset();
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_ready();
        check_outputs();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        ws[0] = 0;
        ws[1] = 2;
        ws[2] = 3;
        rst    = 1'b0;
        rom_en = 1'b0;
        hold   = 1'b0;
        addr   = '0;
        for (int k = 0; k < 1024; k++) begin
            u_ws0.r_mem[k] = 32'(k) + 32'h100;
            u_ws2.r_mem[k] = 32'(k) + 32'h100;
            u_ws3.r_mem[k] = 32'(k) + 32'h100;
        end
        #1;
        model_reset();
        check_ready();
        check_outputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // back-to-back sequential fetches
        step(1'b1, 32'h0, 1'b0);
        step(1'b1, 32'h4, 1'b0);
        step(1'b1, 32'h8, 1'b0);
        step(1'b1, 32'hC, 1'b0);
        idle(5);

        // single fetch through the wait states
        step(1'b1, 32'h10, 1'b0);
        idle(5);

        // misaligned and out-of-range fetches
        step(1'b1, 32'h6, 1'b0);
        step(1'b1, 32'h1000, 1'b0);
        step(1'b1, 32'hFFFF_FFFC, 1'b0);
        idle(5);

        // hold freezes a valid response and blocks the next request
        step(1'b1, 32'h8, 1'b0);
        step(1'b1, 32'hC, 1'b1);
        step(1'b1, 32'hC, 1'b1);
        step(1'b1, 32'hC, 1'b1);
        step(1'b1, 32'hC, 1'b0);
        idle(5);

        // response completing under hold, then frozen until release
        step(1'b1, 32'h8, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1);
        idle(3);

        // rom_en drop after a response keeps data but clears valid
        step(1'b1, 32'h4, 1'b0);
        idle(4);

        // reset mid-wait, then first fetch after release
        step(1'b1, 32'h20, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        pulse_reset();
        step(1'b1, 32'h0, 1'b0);
        idle(5);

        // randomized traffic with occasional resets
        for (int n = 0; n < 800; n++) begin
            logic [31:0] a;
            int          sel;
            sel = $urandom_range(0, 9);
            if (sel < 7)       a = 32'($urandom_range(0, 1023)) << 2;
            else if (sel == 7) a = (32'($urandom_range(0, 1023)) << 2) | 32'($urandom_range(1, 3));
            else if (sel == 8) a = 32'h1000 + (32'($urandom_range(0, 4095)) << 2);
            else               a = $urandom;
            step($urandom_range(0, 3) != 0, a, $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 99) == 0) pulse_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
